// File: rtl/muldiv_seq_nbit.sv
// Iterative RV32M-style multiply/divide unit: shift-add multiplier and restoring
// divider on operand magnitudes, with sign fix-up in a final one-cycle FIX state.
module muldiv_seq_nbit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic           sa_q, sa_d, sb_q, sb_d, fast_q, fast_d;
    logic [N:0]     acc_q, acc_d;
    logic [N-1:0]   lo_q, lo_d, opnd_q, opnd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic [N-1:0]   res_q, res_d;

    logic           accept, a_signed, b_signed, sa_in, sb_in, div0, ovf;
    logic [N-1:0]   a_mag, b_mag, fast_res;
    logic [N:0]     sum, r_sh, diff;
    logic [2*N-1:0] prod, prod_s;
    logic [N-1:0]   quo, rem, fix_res;

    // Operand decode for the request currently on the inputs.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                         a_signed = 1'b1;
            default:                        ;
        endcase
        sa_in  = a_signed & A[N-1];
        sb_in  = b_signed & B[N-1];
        a_mag  = sa_in ? (~A + 1'b1) : A;
        b_mag  = sb_in ? (~B + 1'b1) : B;
        div0   = op[2] && (B == '0);
        ovf    = op[2] && !op[0] && (A == {1'b1, {(N-1){1'b0}}}) && (B == '1);
        fast_res = '0;
        if (div0)
            fast_res = op[1] ? A : '1;
        else if (ovf)
            fast_res = op[1] ? '0 : A;
    end

    assign accept = (state_q == IDLE) && start && !flush;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (div0 || ovf) ? FIX : CALC;
            CALC:    if (flush) state_d = IDLE;
                     else if (cnt_q == CW'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sign fix-up and result selection used in FIX.
    always_comb begin
        prod    = {acc_q[N-1:0], lo_q};
        prod_s  = (sa_q ^ sb_q) ? (~prod + 1'b1) : prod;
        quo     = (sa_q ^ sb_q) ? (~lo_q + 1'b1) : lo_q;
        rem     = sa_q ? (~acc_q[N-1:0] + 1'b1) : acc_q[N-1:0];
        fix_res = op_q[2] ? (op_q[1] ? rem : quo)
                          : ((op_q[1:0] == 2'b00) ? prod_s[N-1:0] : prod_s[2*N-1:N]);
        if (fast_q)
            fix_res = lo_q;
    end

    // FSM: outputs
    always_comb begin
        busy   = (state_q != IDLE);
        done_d = (state_q == FIX) && !flush;
        res_d  = done_d ? fix_res : res_q;
    end

    // Datapath: load on accept, one multiply or divide step per CALC cycle.
    always_comb begin
        op_d   = op_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        fast_d = fast_q;
        acc_d  = acc_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        sum    = acc_q + {1'b0, opnd_q};
        r_sh   = {acc_q[N-1:0], lo_q[N-1]};
        diff   = r_sh - {1'b0, opnd_q};
        if (accept) begin
            op_d   = op;
            sa_d   = sa_in;
            sb_d   = sb_in;
            fast_d = div0 || ovf;
            acc_d  = '0;
            cnt_d  = CW'(N);
            lo_d   = (div0 || ovf) ? fast_res : (op[2] ? a_mag : b_mag);
            opnd_d = op[2] ? b_mag : a_mag;
        end else if (state_q == CALC) begin
            cnt_d = cnt_q - 1'b1;
            if (!op_q[2]) begin
                if (!lo_q[0])
                    sum = acc_q;
                acc_d = {1'b0, sum[N:1]};
                lo_d  = {sum[0], lo_q[N-1:1]};
            end else if (!diff[N]) begin
                acc_d = diff;
                lo_d  = {lo_q[N-2:0], 1'b1};
            end else begin
                acc_d = r_sh;
                lo_d  = {lo_q[N-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            fast_q <= 1'b0;
            acc_q  <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            op_q   <= op_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            fast_q <= fast_d;
            acc_q  <= acc_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            res_q  <= res_d;
        end
    end

    assign done   = done_q;
    assign result = res_q;
endmodule
